reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) for the out-of-order core.
- Each entry records the previous physical tag (old_tag) of an instruction's destination register.
- Allocates entries in program order and marks them complete from four wakeup (completion) buses.
- Retires up to two completed entries per cycle from the head, reporting the freed old tags to the free list.

Parameters:
ROB_SIZE, 64, number of entries; 2..64; index width fixed at 6 bits; indices 0..ROB_SIZE-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
enqueue_enable  input  1  allocate one entry this cycle
enqueue_old_tag  input  6  old physical tag stored in the allocated entry
wakeup_0_active  input  1  completion bus 0 valid
wakeup_0_rob_index  input  6  ROB index completed on bus 0
wakeup_1_active / wakeup_1_rob_index  input  1 / 6  completion bus 1
wakeup_2_active / wakeup_2_rob_index  input  1 / 6  completion bus 2
wakeup_3_active / wakeup_3_rob_index  input  1 / 6  completion bus 3
next_rob_index  output  6  index the next enqueue will occupy (combinational from tail pointer)
freed_tag_1  output  6  registered; old tag of oldest entry retired at last edge, else 0
freed_tag_2  output  6  registered; old tag of second entry retired at last edge, else 0

Behaviour:
- State per entry: valid, complete, old_tag[5:0]. Also head and tail pointers (0..ROB_SIZE-1, wrap to 0 past ROB_SIZE-1) and count (0..ROB_SIZE).
- Reset (reset==0, async): all valid/complete cleared; head=tail=count=0; freed_tag_1=freed_tag_2=0; next_rob_index=0.
- next_rob_index = tail at all times, including when the buffer is full.
- Each rising edge performs the following, evaluated against the state before the edge:
  - Wakeup: for each active bus whose index names a valid entry, set complete. Wakeups to invalid or out-of-range indices are ignored. Duplicate or simultaneous wakeups to the same index are harmless.
  - Retire: the effective complete flag is the stored flag OR any wakeup hitting that index this cycle (same-edge bypass).
  - If head is valid and effectively complete, retire it: freed_tag_1 <= its old_tag.
  - If the next entry (head+1, wrapped) is also valid and effectively complete, retire it too: freed_tag_2 <= its old_tag.
  - Never retire past an incomplete entry. Retirement is strictly in order; a completed younger entry waits for the head.
  - Unused freed outputs load 0. A single retire uses freed_tag_1 with freed_tag_2=0.
  - Retired entries: valid and complete cleared; head advances by the number retired; count decreases accordingly.
  - Enqueue: if enqueue_enable and count (pre-edge) < ROB_SIZE, write entry[tail] = {valid=1, complete=0, old_tag=enqueue_old_tag} and advance tail. If full, the enqueue is dropped silently with no state change. Same-cycle retirement does not make room for that cycle's enqueue.
  - A newly enqueued entry is never retired in its allocation cycle. Wakeups aimed at its index in that same cycle are ignored.
- The freed tag value 0 means "nothing freed"; the free list ignores 0.
- Enqueue, wakeup and retire may all occur in the same cycle. count' = count + enq_accepted - retired.

Test Plan (ROB_SIZE=4):
- Reset, then one clock with no stimulus -> freed_tag_1=0, freed_tag_2=0, next_rob_index=0.
- Enqueue old tags 1,2,3,4 over 4 cycles -> four distinct indices (0,1,2,3) captured from next_rob_index; freed outputs stay 0. A fifth enqueue with tag 9 is dropped (full).
- Wake idx1, then idx2 on separate cycles -> freed outputs 0/0 both cycles (head incomplete).
- Wake idx0 -> on that same edge freed_tag_1=1, freed_tag_2=2. Next idle edge -> freed_tag_1=3, freed_tag_2=0. Following idle edge -> 0/0.
- Wake idx3 -> same edge freed_tag_1=4, freed_tag_2=0. Next idle edge -> 0/0; ROB empty. Further enqueues wrap to indices 0,1.
- Assert reset mid-operation with entries pending -> outputs 0 immediately, next_rob_index=0, and prior entries never retire.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle.
// Groups the allocation request, the four completion (wakeup) buses and the
// retirement outputs of the reorder buffer.
//   enqueue_enable / enqueue_old_tag     : allocate one entry holding old_tag
//   wakeup_N_active / wakeup_N_rob_index : completion bus N (N = 0..3)
//   next_rob_index                       : index the next enqueue will occupy
//   freed_tag_1 / freed_tag_2            : old tags retired at the last edge
// The master modport is the core-side driver; the slave modport is the ROB.
interface reorder_buffer_if;
  logic       enqueue_enable;
  logic [5:0] enqueue_old_tag;
  logic       wakeup_0_active;
  logic [5:0] wakeup_0_rob_index;
  logic       wakeup_1_active;
  logic [5:0] wakeup_1_rob_index;
  logic       wakeup_2_active;
  logic [5:0] wakeup_2_rob_index;
  logic       wakeup_3_active;
  logic [5:0] wakeup_3_rob_index;
  logic [5:0] next_rob_index;
  logic [5:0] freed_tag_1;
  logic [5:0] freed_tag_2;

  modport master (
    output enqueue_enable, enqueue_old_tag,
    output wakeup_0_active, wakeup_0_rob_index,
    output wakeup_1_active, wakeup_1_rob_index,
    output wakeup_2_active, wakeup_2_rob_index,
    output wakeup_3_active, wakeup_3_rob_index,
    input  next_rob_index, freed_tag_1, freed_tag_2
  );

  modport slave (
    input  enqueue_enable, enqueue_old_tag,
    input  wakeup_0_active, wakeup_0_rob_index,
    input  wakeup_1_active, wakeup_1_rob_index,
    input  wakeup_2_active, wakeup_2_rob_index,
    input  wakeup_3_active, wakeup_3_rob_index,
    output next_rob_index, freed_tag_1, freed_tag_2
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer.
// Entries are allocated in program order at the tail, marked complete by any
// of four wakeup buses, and retired from the head, at most two per cycle,
// reporting the freed old physical tags (0 = nothing freed).
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-low reset
//   rob   : reorder_buffer_if.slave (enqueue, wakeups, next index, freed tags)
module reorder_buffer #(
  parameter int ROB_SIZE = 64
) (
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);

  localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CNT_W = 7;

  typedef logic [IDX_W-1:0] ptr_t;
  localparam ptr_t LAST_PTR = ptr_t'(ROB_SIZE - 1);

  // Pointer increment with wrap at ROB_SIZE-1 (ROB_SIZE need not be a power of 2).
  function automatic ptr_t wrap_inc(input ptr_t p);
    if (p == LAST_PTR) wrap_inc = '0;
    else               wrap_inc = p + ptr_t'(1);
  endfunction

  logic             valid_q    [ROB_SIZE];
  logic             valid_d    [ROB_SIZE];
  logic             complete_q [ROB_SIZE];
  logic             complete_d [ROB_SIZE];
  logic [5:0]       tag_q      [ROB_SIZE];
  logic [5:0]       tag_d      [ROB_SIZE];
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       freed_tag_1_q, freed_tag_1_d;
  logic [5:0]       freed_tag_2_q, freed_tag_2_d;

  logic [3:0]       wk_act;
  logic [5:0]       wk_idx [4];
  logic             hit    [ROB_SIZE];

  ptr_t             head_nxt;
  logic             ret_1, ret_2, enq_ok;

  assign wk_act    = {rob.wakeup_3_active, rob.wakeup_2_active,
                      rob.wakeup_1_active, rob.wakeup_0_active};
  assign wk_idx[0] = rob.wakeup_0_rob_index;
  assign wk_idx[1] = rob.wakeup_1_rob_index;
  assign wk_idx[2] = rob.wakeup_2_rob_index;
  assign wk_idx[3] = rob.wakeup_3_rob_index;

  // Per-entry wakeup hit; out-of-range indices simply match no entry.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      hit[i] = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (wk_act[b] && (wk_idx[b] == 6'(i))) hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    head_nxt = wrap_inc(head_q);
    // Effective completion bypasses this cycle's wakeups into retirement.
    ret_1  = valid_q[head_q] && (complete_q[head_q] || hit[head_q]);
    ret_2  = ret_1 && valid_q[head_nxt] && (complete_q[head_nxt] || hit[head_nxt]);
    // Uses the pre-edge count: same-cycle retirement does not free a slot.
    enq_ok = rob.enqueue_enable && (count_q < CNT_W'(ROB_SIZE));

    for (int i = 0; i < ROB_SIZE; i++) begin
      valid_d[i]    = valid_q[i];
      complete_d[i] = complete_q[i] || (valid_q[i] && hit[i]);
      tag_d[i]      = tag_q[i];
    end

    if (ret_1) begin
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (ret_2) begin
      valid_d[head_nxt]    = 1'b0;
      complete_d[head_nxt] = 1'b0;
    end

    // The tail entry is invalid pre-edge whenever enq_ok holds, so wakeups
    // aimed at it this cycle never set complete; the write below wins anyway.
    if (enq_ok) begin
      valid_d[tail_q]    = 1'b1;
      complete_d[tail_q] = 1'b0;
      tag_d[tail_q]      = rob.enqueue_old_tag;
    end

    if (ret_2)      head_d = wrap_inc(head_nxt);
    else if (ret_1) head_d = head_nxt;
    else            head_d = head_q;

    tail_d  = enq_ok ? wrap_inc(tail_q) : tail_q;
    count_d = count_q + CNT_W'(enq_ok) - CNT_W'(ret_1) - CNT_W'(ret_2);

    freed_tag_1_d = ret_1 ? tag_q[head_q]   : 6'd0;
    freed_tag_2_d = ret_2 ? tag_q[head_nxt] : 6'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        valid_q[i]    <= 1'b0;
        complete_q[i] <= 1'b0;
        tag_q[i]      <= 6'd0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      freed_tag_1_q <= 6'd0;
      freed_tag_2_q <= 6'd0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        valid_q[i]    <= valid_d[i];
        complete_q[i] <= complete_d[i];
        tag_q[i]      <= tag_d[i];
      end
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      freed_tag_1_q <= freed_tag_1_d;
      freed_tag_2_q <= freed_tag_2_d;
    end
  end

  assign rob.next_rob_index = 6'(tail_q);
  assign rob.freed_tag_1    = freed_tag_1_q;
  assign rob.freed_tag_2    = freed_tag_2_q;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic reset;

  reorder_buffer_if rif ();

  reorder_buffer #(.ROB_SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        enq;
    logic [5:0]  tag;
    logic [3:0]  wa;
    logic [23:0] wi;   // {idx3, idx2, idx1, idx0}
    logic [5:0]  f1;
    logic [5:0]  f2;
    logic [5:0]  nx;
  } vec_t;

  typedef struct packed {
    logic [5:0] f1;
    logic [5:0] f2;
    logic [5:0] nx;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic e, input logic [5:0] t, input logic [3:0] wa,
                              input logic [5:0] w0, input logic [5:0] w1,
                              input logic [5:0] w2, input logic [5:0] w3,
                              input logic [5:0] f1, input logic [5:0] f2,
                              input logic [5:0] nx);
    vec_t r;
    r.enq = e;  r.tag = t;  r.wa = wa;  r.wi = {w3, w2, w1, w0};
    r.f1 = f1;  r.f2 = f2;  r.nx = nx;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rif.enqueue_enable     = v.enq;
    rif.enqueue_old_tag    = v.tag;
    rif.wakeup_0_active    = v.wa[0];
    rif.wakeup_1_active    = v.wa[1];
    rif.wakeup_2_active    = v.wa[2];
    rif.wakeup_3_active    = v.wa[3];
    rif.wakeup_0_rob_index = v.wi[5:0];
    rif.wakeup_1_rob_index = v.wi[11:6];
    rif.wakeup_2_rob_index = v.wi[17:12];
    rif.wakeup_3_rob_index = v.wi[23:18];
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check_outputs(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      cmp({name, ".freed_tag_1"}, rif.freed_tag_1, e.f1);
      cmp({name, ".freed_tag_2"}, rif.freed_tag_2, e.f2);
      cmp({name, ".next_rob_index"}, rif.next_rob_index, e.nx);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input string name, input vec_t v);
    drive(v);
    exp_q.push_back({v.f1, v.f2, v.nx});
    @(posedge clk);
    #1;
    check_outputs(name);
    @(negedge clk);
  endtask

  initial begin
    // ---------------- vector table (ROB_SIZE = 4) ----------------
    //               enq tag wa      w0 w1 w2 w3   f1 f2 nx
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // idle after reset
    tbl.push_back(mk(1, 1, 4'b0000, 0, 0, 0, 0,    0, 0, 1)); // idx0 tag1
    tbl.push_back(mk(1, 2, 4'b0000, 0, 0, 0, 0,    0, 0, 2)); // idx1 tag2
    tbl.push_back(mk(1, 3, 4'b0000, 0, 0, 0, 0,    0, 0, 3)); // idx2 tag3
    tbl.push_back(mk(1, 4, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // idx3 tag4, full
    tbl.push_back(mk(1, 9, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // dropped
    tbl.push_back(mk(0, 0, 4'b0001, 1, 0, 0, 0,    0, 0, 0)); // wake1, head incomplete
    tbl.push_back(mk(0, 0, 4'b0010, 0, 2, 0, 0,    0, 0, 0)); // wake2
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 0, 0,    1, 2, 0)); // wake0 -> retire 0,1
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    3, 0, 0)); // idx2 retires
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // idx3 incomplete
    tbl.push_back(mk(0, 0, 4'b1000, 0, 0, 0, 3,    4, 0, 0)); // wake3 -> retire
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // empty
    tbl.push_back(mk(1, 5, 4'b0000, 0, 0, 0, 0,    0, 0, 1)); // wrap idx0 tag5
    tbl.push_back(mk(1, 6, 4'b0000, 0, 0, 0, 0,    0, 0, 2)); // idx1 tag6
    tbl.push_back(mk(1, 7, 4'b0011, 2, 4, 0, 0,    0, 0, 3)); // idx2 tag7; wake new/out-of-range
    tbl.push_back(mk(0, 0, 4'b0011, 1, 1, 0, 0,    0, 0, 3)); // duplicate wake1
    tbl.push_back(mk(1, 8, 4'b1000, 0, 0, 0, 0,    5, 6, 0)); // wake0 + enq idx3 tag8
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 0)); // idx2 never woken
    tbl.push_back(mk(0, 0, 4'b0100, 0, 0, 3, 0,    0, 0, 0)); // younger waits
    tbl.push_back(mk(0, 0, 4'b0001, 2, 0, 0, 0,    7, 8, 0)); // wake2 -> retire 2,3
    tbl.push_back(mk(1, 10, 4'b0000, 0, 0, 0, 0,   0, 0, 1));
    tbl.push_back(mk(1, 11, 4'b0000, 0, 0, 0, 0,   0, 0, 2));
    tbl.push_back(mk(1, 12, 4'b0000, 0, 0, 0, 0,   0, 0, 3));
    tbl.push_back(mk(1, 13, 4'b0000, 0, 0, 0, 0,   0, 0, 0)); // full
    tbl.push_back(mk(1, 14, 4'b0001, 0, 0, 0, 0,  10, 0, 0)); // retire while full: enq dropped
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 0));
    tbl.push_back(mk(1, 15, 4'b0000, 0, 0, 0, 0,   0, 0, 1)); // idx0 tag15
    tbl.push_back(mk(0, 0, 4'b0111, 1, 2, 3, 0,   11, 12, 1)); // max two retire
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,   13, 0, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 0,    0, 0, 1)); // idx0 incomplete
    tbl.push_back(mk(1, 16, 4'b0000, 0, 0, 0, 0,   0, 0, 2)); // idx1 tag16

    // ---------------- reset state ----------------
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    cmp("reset.freed_tag_1", rif.freed_tag_1, 6'd0);
    cmp("reset.freed_tag_2", rif.freed_tag_2, 6'd0);
    cmp("reset.next_rob_index", rif.next_rob_index, 6'd0);
    reset = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // ---------------- async reset mid-operation ----------------
    // Pending: idx0 tag15 (incomplete), idx1 tag16. Retire idx0 so an output is non-zero.
    drive(mk(0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    cmp("pre_reset.freed_tag_1", rif.freed_tag_1, 6'd15);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    cmp("async_reset.freed_tag_1", rif.freed_tag_1, 6'd0);
    cmp("async_reset.freed_tag_2", rif.freed_tag_2, 6'd0);
    cmp("async_reset.next_rob_index", rif.next_rob_index, 6'd0);
    @(negedge clk);
    reset = 1'b1;
    // Former entries were cleared: waking them must retire nothing.
    step("post_reset_wake", mk(0, 0, 4'b0011, 0, 1, 0, 0, 0, 0, 0));
    step("post_reset_idle", mk(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    step("post_reset_enq",  mk(1, 20, 4'b0000, 0, 0, 0, 0, 0, 0, 1));
    step("post_reset_ret",  mk(0, 0, 4'b0001, 0, 0, 0, 0, 20, 0, 1));

    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
